// File: rtl/signal_generator_multi.sv
// Phase-accumulator tone source: triangle / sawtooth / pulse (and sine when
// SIGGEN_SINE_EN is defined), settings applied only at period boundaries.
module signal_generator_multi #(
  parameter int unsigned SAMPLE_RATE = 32000,
  parameter int unsigned FREQ_W      = 14,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned IDX_W       = 7
) (
  input  logic              CLK_32KHz,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        waveSelect,
  input  logic [FREQ_W-1:0] inputFrequency,
  input  logic [IDX_W-1:0]  dutyCycle,
  input  logic [7:0]        amplitude,
  output logic [OUT_W-1:0]  outputSample,
  output logic              sampleValid,
  output logic              indexZero
);

  localparam int unsigned PH_W = $clog2(SAMPLE_RATE + 2**FREQ_W);
  localparam int unsigned N    = 2**IDX_W;
  localparam int unsigned NYQ  = SAMPLE_RATE / 2;
  localparam int unsigned XW   = PH_W + IDX_W;
  localparam int unsigned TW   = IDX_W + OUT_W + 1;
  localparam int unsigned PW   = OUT_W + 8;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic   start;

  logic [FREQ_W-1:0] sh_freq;
  logic [1:0]        sh_wave;
  logic [IDX_W-1:0]  sh_duty;
  logic [7:0]        sh_amp;
  logic [PH_W-1:0]   sh_freq_cl;

  logic [PH_W-1:0]   act_freq;
  logic [1:0]        act_wave;
  logic [IDX_W-1:0]  act_duty;
  logic [7:0]        act_amp;

  logic [PH_W-1:0]   eff_freq;
  logic [1:0]        eff_wave;
  logic [IDX_W-1:0]  eff_duty;
  logic [7:0]        eff_amp;

  logic [PH_W-1:0]   phase, sum;
  logic              wrap, wrapped;
  logic [XW-1:0]     ph_x;
  logic [IDX_W-1:0]  idx;
  logic [OUT_W-1:0]  tri_raw, raw;

  logic [OUT_W-1:0]  raw1;
  logic [7:0]        amp1;
  logic              v1, z1;
  logic [PW-1:0]     prod;

`ifdef SIGGEN_SINE_EN
  typedef logic [OUT_W-1:0] rom_t [N];

  function automatic rom_t gen_sine();
    rom_t r;
    real  half;
    half = real'(2**OUT_W - 1) / 2.0;
    for (int unsigned i = 0; i < N; i++)
      r[i] = OUT_W'($rtoi(half + half * $sin(2.0 * 3.14159265358979 * real'(i) / real'(N)) + 0.5));
    return r;
  endfunction

  localparam rom_t SINE_ROM = gen_sine();
`endif

  always_ff @(posedge CLK_32KHz) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if (enable) begin
        state_nxt = RUN;
        start     = 1'b1;
      end
      RUN:  if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sh_freq_cl = (PH_W'(sh_freq) > PH_W'(NYQ)) ? PH_W'(NYQ) : PH_W'(sh_freq);

  // On the idle->run cycle the active set is still stale, so use the shadow directly.
  assign eff_freq = start ? sh_freq_cl : act_freq;
  assign eff_wave = start ? sh_wave    : act_wave;
  assign eff_duty = start ? sh_duty    : act_duty;
  assign eff_amp  = start ? sh_amp     : act_amp;

  assign sum  = phase + eff_freq;
  assign wrap = (sum >= PH_W'(SAMPLE_RATE));
  assign ph_x = XW'(phase) << IDX_W;
  assign idx  = IDX_W'(ph_x / XW'(SAMPLE_RATE));

  always_comb begin
    tri_raw = '0;
    if (idx < IDX_W'(N / 2))
      tri_raw = OUT_W'((TW'(idx) << (OUT_W + 1)) >> IDX_W);
    else if (idx == IDX_W'(N / 2))
      tri_raw = '1;
    else
      tri_raw = OUT_W'(((TW'(N) - TW'(idx)) << (OUT_W + 1)) >> IDX_W);
  end

  always_comb begin
    raw = tri_raw;
    case (eff_wave)
      2'd1: raw = OUT_W'((TW'(idx) << OUT_W) >> IDX_W);
      2'd2: raw = (idx < eff_duty) ? '1 : '0;
`ifdef SIGGEN_SINE_EN
      2'd3: raw = SINE_ROM[idx];
`endif
      default: raw = tri_raw;
    endcase
  end

  assign prod = PW'(raw1) * PW'({1'b0, amp1} + 9'd1);

  always_ff @(posedge CLK_32KHz) begin
    sh_freq <= inputFrequency;
    sh_wave <= waveSelect;
    sh_duty <= dutyCycle;
    sh_amp  <= amplitude;
    if (reset) begin
      phase        <= '0;
      wrapped      <= 1'b0;
      act_freq     <= '0;
      act_wave     <= '0;
      act_duty     <= '0;
      act_amp      <= '0;
      raw1         <= '0;
      amp1         <= '0;
      v1           <= 1'b0;
      z1           <= 1'b0;
      outputSample <= '0;
      sampleValid  <= 1'b0;
      indexZero    <= 1'b0;
    end else begin
      if (enable) begin
        phase   <= wrap ? PH_W'(sum - PH_W'(SAMPLE_RATE)) : sum;
        wrapped <= wrap;
        if (start || wrap) begin
          act_freq <= sh_freq_cl;
          act_wave <= sh_wave;
          act_duty <= sh_duty;
          act_amp  <= sh_amp;
        end
        raw1 <= raw;
        amp1 <= eff_amp;
        v1   <= 1'b1;
        z1   <= start | wrapped;
      end else begin
        phase   <= '0;
        wrapped <= 1'b0;
        raw1    <= '0;
        amp1    <= '0;
        v1      <= 1'b0;
        z1      <= 1'b0;
      end
      outputSample <= OUT_W'(prod >> 8);
      sampleValid  <= v1;
      indexZero    <= z1;
    end
  end

endmodule

// File: tb/tb_signal_generator_multi.sv
// Bench for signal_generator_multi: behavioural model plus directed pattern checks.
module tb_signal_generator_multi;
  localparam int SR  = 32000;
  localparam int NST = 128;
  localparam int NYQ = SR / 2;

  logic       CLK_32KHz = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] waveSelect = '0;
  logic [13:0] inputFrequency = '0;
  logic [6:0] dutyCycle = '0;
  logic [7:0] amplitude = '0;
  logic [7:0] outputSample;
  logic       sampleValid, indexZero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK_32KHz = ~CLK_32KHz;

  signal_generator_multi #(
    .SAMPLE_RATE(SR), .FREQ_W(14), .OUT_W(8), .IDX_W(7)
  ) dut (
    .CLK_32KHz(CLK_32KHz), .reset(reset), .enable(enable),
    .waveSelect(waveSelect), .inputFrequency(inputFrequency),
    .dutyCycle(dutyCycle), .amplitude(amplitude),
    .outputSample(outputSample), .sampleValid(sampleValid), .indexZero(indexZero)
  );

  function automatic int raw_of(int w, int idx, int d);
    if (w == 1) return idx * 256 / NST;
    if (w == 2) return (idx < d) ? 255 : 0;
`ifdef SIGGEN_SINE_EN
    if (w == 3) return $rtoi(127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * real'(idx) / real'(NST)) + 0.5);
`endif
    if (idx < NST / 2) return idx * 512 / NST;
    if (idx == NST / 2) return 255;
    return (NST - idx) * 512 / NST;
  endfunction

  function automatic int clampf(int f);
    return (f > NYQ) ? NYQ : f;
  endfunction

  // Reference model: one sample per edge, output appears one edge after it is formed.
  int   m_phase, sh_f, sh_w, sh_d, sh_a, a_f, a_w, a_d, a_a, p_s;
  bit   m_run, m_wrap, p_v, p_z;
  logic e_v, e_z;
  logic [7:0] e_s;

  always @(posedge CLK_32KHz) begin : model
    int f, w, d, a, idx, n_s;
    bit st, n_v, n_z;
    if (reset) begin
      m_phase = 0; m_run = 0; m_wrap = 0;
      a_f = 0; a_w = 0; a_d = 0; a_a = 0;
      p_v = 0; p_z = 0; p_s = 0;
      e_v = 0; e_z = 0; e_s = 0;
    end else begin
      e_v = p_v; e_z = p_z; e_s = 8'(p_s);
      if (enable) begin
        st  = !m_run;
        f   = st ? clampf(sh_f) : a_f;
        w   = st ? sh_w : a_w;
        d   = st ? sh_d : a_d;
        a   = st ? sh_a : a_a;
        idx = m_phase * NST / SR;
        n_v = 1;
        n_z = st || m_wrap;
        n_s = raw_of(w, idx, d) * (a + 1) / 256;
        m_phase = m_phase + f;
        m_wrap  = (m_phase >= SR);
        if (m_wrap) m_phase = m_phase - SR;
        if (st || m_wrap) begin
          a_f = clampf(sh_f); a_w = sh_w; a_d = sh_d; a_a = sh_a;
        end
      end else begin
        n_v = 0; n_z = 0; n_s = 0;
        m_phase = 0; m_wrap = 0;
      end
      m_run = enable;
      p_v = n_v; p_z = n_z; p_s = n_s;
    end
    sh_f = int'(inputFrequency); sh_w = int'(waveSelect);
    sh_d = int'(dutyCycle);      sh_a = int'(amplitude);
  end

  task automatic go_idle(input int n);
    enable = 1'b0;
    repeat (n) @(negedge CLK_32KHz);
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0;
    waveSelect = 2'd0; inputFrequency = 14'd1000; amplitude = 8'd255; dutyCycle = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK_32KHz);
      if (k == 3) reset = 1'b0;
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== 10'd0) begin
        n_bad++;
        $display("FAIL reset_state k=%0d got v%b z%b s%0d want v0 z0 s0", k, sampleValid, indexZero, outputSample);
      end
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== {e_v, e_z, e_s}) begin
        n_bad++;
        $display("FAIL reset_model k=%0d got v%b z%b s%0d want v%b z%b s%0d", k, sampleValid, indexZero, outputSample, e_v, e_z, e_s);
      end
    end
  endtask

  task automatic test_triangle;
    logic [9:0] ex;
    int j;
    waveSelect = 2'd0; inputFrequency = 14'd1000; amplitude = 8'd255;
    go_idle(2);
    enable = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLK_32KHz);
      j  = (k - 2) % 32;
      ex = (k < 2) ? 10'd0 : {1'b1, j == 0, 8'((j < 16) ? 16 * j : (j == 16) ? 255 : (32 - j) * 16)};
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== ex) begin
        n_bad++;
        $display("FAIL tri_1000 k=%0d got %b want %b", k, {sampleValid, indexZero, outputSample}, ex);
      end
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== {e_v, e_z, e_s}) begin
        n_bad++;
        $display("FAIL tri_model k=%0d got v%b z%b s%0d want v%b z%b s%0d", k, sampleValid, indexZero, outputSample, e_v, e_z, e_s);
      end
    end
  endtask

  task automatic test_saw_amp;
    logic [9:0] ex;
    int j, mx;
    go_idle(3);
    waveSelect = 2'd1; inputFrequency = 14'd500; amplitude = 8'd255;
    repeat (2) @(negedge CLK_32KHz);
    enable = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      @(negedge CLK_32KHz);
      j  = (k - 2) % 64;
      ex = (k < 2) ? 10'd0 : {1'b1, j == 0, 8'(4 * j)};
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== ex) begin
        n_bad++;
        $display("FAIL saw_500 k=%0d got %b want %b", k, {sampleValid, indexZero, outputSample}, ex);
      end
    end
    waveSelect = 2'd0; inputFrequency = 14'd1000; amplitude = 8'd127;
    mx = 0;
    for (int k = 1; k <= 160; k++) begin
      @(negedge CLK_32KHz);
      if (k >= 100 && int'(outputSample) > mx) mx = int'(outputSample);
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== {e_v, e_z, e_s}) begin
        n_bad++;
        $display("FAIL amp_model k=%0d got v%b z%b s%0d want v%b z%b s%0d", k, sampleValid, indexZero, outputSample, e_v, e_z, e_s);
      end
    end
    n_cmp++;
    if (mx != 127) begin
      n_bad++;
      $display("FAIL tri_half_peak got %0d want 127", mx);
    end
    for (int r = 0; r < 4; r++) begin
      amplitude = 8'($urandom_range(0, 255));
      for (int k = 0; k < 40; k++) begin
        @(negedge CLK_32KHz);
        n_cmp++;
        if ({sampleValid, indexZero, outputSample} !== {e_v, e_z, e_s}) begin
          n_bad++;
          $display("FAIL rand_amp_model amp=%0d got v%b z%b s%0d want v%b z%b s%0d", amplitude, sampleValid, indexZero, outputSample, e_v, e_z, e_s);
        end
      end
    end
  endtask

  task automatic test_freq_change;
    int q[$];
    int ch, g0, g1, g2;
    go_idle(3);
    waveSelect = 2'd0; inputFrequency = 14'd1000; amplitude = 8'd255;
    repeat (2) @(negedge CLK_32KHz);
    enable = 1'b1;
    ch = $urandom_range(5, 29);
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLK_32KHz);
      if (indexZero === 1'b1) q.push_back(k);
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== {e_v, e_z, e_s}) begin
        n_bad++;
        $display("FAIL freq_change_model k=%0d got v%b z%b s%0d want v%b z%b s%0d", k, sampleValid, indexZero, outputSample, e_v, e_z, e_s);
      end
      if (k == ch) inputFrequency = 14'd2000;
    end
    g0 = (q.size() > 1) ? q[1] - q[0] : -1;
    g1 = (q.size() > 2) ? q[2] - q[1] : -1;
    g2 = (q.size() > 3) ? q[3] - q[2] : -1;
    n_cmp++;
    if (g0 != 32 || g1 != 16 || g2 != 16) begin
      n_bad++;
      $display("FAIL freq_change_period gaps %0d,%0d,%0d want 32,16,16", g0, g1, g2);
    end
  endtask

  task automatic test_square;
    logic [9:0] ex;
    int j, nz;
    go_idle(3);
    waveSelect = 2'd2; inputFrequency = 14'd250; dutyCycle = 7'd32; amplitude = 8'd255;
    repeat (2) @(negedge CLK_32KHz);
    enable = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(negedge CLK_32KHz);
      j  = (k - 2) % 128;
      ex = (k < 2) ? 10'd0 : {1'b1, j == 0, 8'((j < 32) ? 255 : 0)};
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== ex) begin
        n_bad++;
        $display("FAIL square_duty32 k=%0d got %b want %b", k, {sampleValid, indexZero, outputSample}, ex);
      end
    end
    dutyCycle = 7'd0;
    nz = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge CLK_32KHz);
      if (k >= 130 && outputSample != 8'd0) nz++;
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== {e_v, e_z, e_s}) begin
        n_bad++;
        $display("FAIL duty0_model k=%0d got v%b z%b s%0d want v%b z%b s%0d", k, sampleValid, indexZero, outputSample, e_v, e_z, e_s);
      end
    end
    n_cmp++;
    if (nz != 0) begin
      n_bad++;
      $display("FAIL duty0_const nonzero samples %0d want 0", nz);
    end
    dutyCycle = 7'($urandom_range(1, 127));
    for (int k = 1; k <= 260; k++) begin
      @(negedge CLK_32KHz);
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== {e_v, e_z, e_s}) begin
        n_bad++;
        $display("FAIL rand_duty_model duty=%0d got v%b z%b s%0d want v%b z%b s%0d", dutyCycle, sampleValid, indexZero, outputSample, e_v, e_z, e_s);
      end
    end
  endtask

  task automatic test_nyquist;
    logic [9:0] ex;
    int j;
    go_idle(3);
    waveSelect = 2'd0; inputFrequency = 14'd16383; amplitude = 8'd255;
    repeat (2) @(negedge CLK_32KHz);
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK_32KHz);
      j  = (k - 2) % 2;
      ex = (k < 2) ? 10'd0 : {1'b1, j == 0, 8'((j == 0) ? 0 : 255)};
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== ex) begin
        n_bad++;
        $display("FAIL nyquist_clamp k=%0d got %b want %b", k, {sampleValid, indexZero, outputSample}, ex);
      end
    end
  endtask

  task automatic test_enable_reset;
    logic [9:0] ex;
    waveSelect = 2'd1; inputFrequency = 14'd1000; amplitude = 8'd200;
    @(negedge CLK_32KHz);
    enable = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK_32KHz);
      n_cmp++;
      if (k >= 2 && {sampleValid, indexZero, outputSample} !== 10'd0) begin
        n_bad++;
        $display("FAIL enable_drop k=%0d got %b want 0", k, {sampleValid, indexZero, outputSample});
      end
    end
    enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK_32KHz);
      ex = (k == 2) ? {1'b1, 1'b1, 8'd0} : (k == 3) ? {1'b1, 1'b0, 8'd6} : 10'd0;
      n_cmp++;
      if ((k == 2 || k == 3) && {sampleValid, indexZero, outputSample} !== ex) begin
        n_bad++;
        $display("FAIL reenable k=%0d got %b want %b", k, {sampleValid, indexZero, outputSample}, ex);
      end
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== {e_v, e_z, e_s}) begin
        n_bad++;
        $display("FAIL reenable_model k=%0d got v%b z%b s%0d want v%b z%b s%0d", k, sampleValid, indexZero, outputSample, e_v, e_z, e_s);
      end
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge CLK_32KHz);
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== 10'd0) begin
        n_bad++;
        $display("FAIL reset_abort got %b want 0", {sampleValid, indexZero, outputSample});
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK_32KHz);
      ex = (k == 2) ? {1'b1, 1'b1, 8'd0} : (k == 3) ? {1'b1, 1'b0, 8'd6} : 10'd0;
      n_cmp++;
      if ((k == 2 || k == 3) && {sampleValid, indexZero, outputSample} !== ex) begin
        n_bad++;
        $display("FAIL post_reset k=%0d got %b want %b", k, {sampleValid, indexZero, outputSample}, ex);
      end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 2000; k++) begin
      @(negedge CLK_32KHz);
      n_cmp++;
      if ({sampleValid, indexZero, outputSample} !== {e_v, e_z, e_s}) begin
        n_bad++;
        $display("FAIL random_model k=%0d got v%b z%b s%0d want v%b z%b s%0d", k, sampleValid, indexZero, outputSample, e_v, e_z, e_s);
      end
      case ($urandom_range(0, 39))
        0: waveSelect = 2'($urandom_range(0, 3));
        1: inputFrequency = 14'($urandom_range(0, 16383));
        2: inputFrequency = 14'($urandom_range(0, 3000));
        3: dutyCycle = 7'($urandom_range(0, 127));
        4: amplitude = 8'($urandom_range(0, 255));
        5: enable = ~enable;
        default: ;
      endcase
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_saw_amp();
    test_freq_change();
    test_square();
    test_nyquist();
    test_enable_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
